// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubble insertion and whole-pipe freeze
// while an imem/dmem request is outstanding, plus stall performance counters.
module hazard_stall_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_id_valid,
  input  logic [6:0]           i_id_opcode,
  input  logic [4:0]           i_id_rs1_s,
  input  logic [4:0]           i_id_rs2_s,
  input  logic                 i_ex_valid,
  input  logic [6:0]           i_ex_opcode,
  input  logic [4:0]           i_ex_rd_s,
  input  logic                 i_imem_req,
  input  logic                 i_imem_resp,
  input  logic                 i_dmem_req,
  input  logic                 i_dmem_resp,
  output logic                 o_pc_stall,
  output logic                 o_if_id_stall,
  output logic                 o_id_ex_stall,
  output logic                 o_ex_mem_stall,
  output logic                 o_mem_wb_stall,
  output logic                 o_id_ex_bubble,
  output logic [CNT_WIDTH-1:0] o_load_use_cnt,
  output logic [CNT_WIDTH-1:0] o_mem_stall_cnt
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_MEM  = 2'd1,
    ST_WAIT_INST = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_imem_pending;
  logic [CNT_WIDTH-1:0]  r_load_use_cnt;
  logic [CNT_WIDTH-1:0]  r_mem_stall_cnt;

  logic w_dmem_pending;
  logic w_imem_pending_nxt;
  logic w_dmem_pending_nxt;
  logic w_freeze;
  logic w_rs1_used;
  logic w_rs2_used;
  logic w_load_use;
  logic w_bubble;

  // The dmem pending flag is carried by the state itself: WAIT_MEM <=> dmem outstanding.
  assign w_dmem_pending     = (r_state == ST_WAIT_MEM);
  assign w_dmem_pending_nxt = (w_dmem_pending & ~i_dmem_resp) | i_dmem_req;
  assign w_imem_pending_nxt = (r_imem_pending & ~i_imem_resp) | i_imem_req;

  assign w_freeze = (w_dmem_pending & ~i_dmem_resp) | (r_imem_pending & ~i_imem_resp);

  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (i_id_opcode)
      OP_JALR, OP_LOAD, OP_IMM: w_rs1_used = 1'b1;
      OP_BR, OP_STORE, OP_REG: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: ;
      default: ;
    endcase
  end

  assign w_load_use = i_id_valid & i_ex_valid & (i_ex_opcode == OP_LOAD) & (i_ex_rd_s != 5'd0) &
                      ((w_rs1_used & (i_id_rs1_s == i_ex_rd_s)) |
                       (w_rs2_used & (i_id_rs2_s == i_ex_rd_s)));

  // A hazard seen during a freeze is simply re-evaluated once the freeze lifts.
  assign w_bubble = w_load_use & ~w_freeze;

  assign o_pc_stall      = w_freeze | w_bubble;
  assign o_if_id_stall   = w_freeze | w_bubble;
  assign o_id_ex_stall   = w_freeze;
  assign o_ex_mem_stall  = w_freeze;
  assign o_mem_wb_stall  = w_freeze;
  assign o_id_ex_bubble  = w_bubble;
  assign o_load_use_cnt  = r_load_use_cnt;
  assign o_mem_stall_cnt = r_mem_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_RUN;
      r_imem_pending  <= 1'b0;
      r_load_use_cnt  <= '0;
      r_mem_stall_cnt <= '0;
    end else begin
      r_imem_pending <= w_imem_pending_nxt;
      if (w_dmem_pending_nxt)      r_state <= ST_WAIT_MEM;
      else if (w_imem_pending_nxt) r_state <= ST_WAIT_INST;
      else                         r_state <= ST_RUN;
      if (w_bubble) r_load_use_cnt  <= r_load_use_cnt + CNT_ONE;
      if (w_freeze) r_mem_stall_cnt <= r_mem_stall_cnt + CNT_ONE;
    end
  end

endmodule
